// File: rtl/gcn_pkg.sv
// Shared GCN transformation-path definitions: default geometry, derived
// address widths and the feature_transform_ctrl state encoding.
package gcn_pkg;

    localparam int FT_NUM_NODES      = 6;
    localparam int FT_WEIGHT_ROWS    = 96;
    localparam int FT_WEIGHT_COLS    = 3;
    localparam int FT_WEIGHT_WIDTH   = 5;
    localparam int FT_DOT_PROD_WIDTH = 16;

    localparam int FT_NODE_AW = $clog2(FT_NUM_NODES);
    localparam int FT_COL_AW  = $clog2(FT_WEIGHT_COLS);
    localparam int FT_FMWM_AW = $clog2(FT_NUM_NODES * FT_WEIGHT_COLS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_W = 3'd1,
        LATCH_W = 3'd2,
        STREAM  = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } ft_state_t;

endpackage

// File: rtl/fm_wm_pipe.sv
// Feature-operand / result pipeline between the feature memory, vectormul and
// the FM x WM product memory. Stage 1: read data arriving; stage 2: operand
// registered into vectormul; stage 3: result registered and written.
module fm_wm_pipe
    import gcn_pkg::*;
#(
    parameter int WEIGHT_ROWS    = FT_WEIGHT_ROWS,
    parameter int WEIGHT_WIDTH   = FT_WEIGHT_WIDTH,
    parameter int DOT_PROD_WIDTH = FT_DOT_PROD_WIDTH,
    parameter int ADDR_W         = FT_FMWM_AW
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     issue,
    input  logic [ADDR_W-1:0]                        tag_in,
    input  logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] feature_line,
    input  logic [DOT_PROD_WIDTH-1:0]                mul_out,
    output logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] vm_feature_line,
    output logic                                     pending,
    output logic                                     write_enable,
    output logic [ADDR_W-1:0]                        write_address,
    output logic [DOT_PROD_WIDTH-1:0]                write_data
);

    localparam int STAGES = 3;

    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][ADDR_W-1:0] tag_pipe;

    // Valid/tag shift register; the read issue is the stage-0 valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], issue};
            tag_pipe <= {tag_pipe[STAGES-1:1], tag_in};
        end
    end

    // Operand and result registers, loaded only when their stage carries data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vm_feature_line <= '0;
            write_data      <= '0;
        end else begin
            if (vld_pipe[1]) vm_feature_line <= feature_line;
            if (vld_pipe[2]) write_data      <= mul_out;
        end
    end

    // Work still in flight that has not reached the write stage yet.
    assign pending       = |vld_pipe[2:1];
    assign write_enable  = vld_pipe[3];
    assign write_address = tag_pipe[3];

endmodule

// File: rtl/feature_transform_ctrl.sv
// Sequencer feeding vectormul: per weight column, fetch the column once, then
// stream all feature rows past it and write results row-major to FM x WM.
// Optional build macro FEATURE_TRANSFORM_CYCLE_CNT_EN adds a busy_cycles port.
module feature_transform_ctrl
    import gcn_pkg::*;
#(
    parameter int NUM_NODES      = FT_NUM_NODES,
    parameter int WEIGHT_ROWS    = FT_WEIGHT_ROWS,
    parameter int WEIGHT_COLS    = FT_WEIGHT_COLS,
    parameter int WEIGHT_WIDTH   = FT_WEIGHT_WIDTH,
    parameter int DOT_PROD_WIDTH = FT_DOT_PROD_WIDTH,
    localparam int NODE_AW = $clog2(NUM_NODES),
    localparam int COL_AW  = $clog2(WEIGHT_COLS),
    localparam int FMWM_AW = $clog2(NUM_NODES * WEIGHT_COLS)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    output logic                                     read_enable_weight,
    output logic [COL_AW-1:0]                        read_address_weight,
    input  logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] weight_line,
    output logic                                     read_enable_feature,
    output logic [NODE_AW-1:0]                       read_address_feature,
    input  logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] feature_line,
    output logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] vm_weight_line,
    output logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] vm_feature_line,
    input  logic [DOT_PROD_WIDTH-1:0]                vm_mul_out,
    output logic                                     write_enable_fm_wm,
    output logic [FMWM_AW-1:0]                       write_address_fm_wm,
    output logic [DOT_PROD_WIDTH-1:0]                write_data_fm_wm,
    output logic                                     done
`ifdef FEATURE_TRANSFORM_CYCLE_CNT_EN
   ,output logic [15:0]                              busy_cycles
`endif
);

    localparam logic [COL_AW-1:0]  COL_LAST  = COL_AW'(WEIGHT_COLS - 1);
    localparam logic [NODE_AW-1:0] NODE_LAST = NODE_AW'(NUM_NODES - 1);

    ft_state_t           state, state_nxt;
    logic [COL_AW-1:0]   col;
    logic [NODE_AW-1:0]  node;
    logic                pending;
    logic [FMWM_AW-1:0]  tag;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and memory-read strobes.
    always_comb begin
        state_nxt            = state;
        read_enable_weight   = 1'b0;
        read_address_weight  = '0;
        read_enable_feature  = 1'b0;
        read_address_feature = '0;
        done                 = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = FETCH_W;
            FETCH_W: begin
                read_enable_weight  = 1'b1;
                read_address_weight = col;
                state_nxt           = LATCH_W;
            end
            LATCH_W: state_nxt = STREAM;
            STREAM: begin
                read_enable_feature  = 1'b1;
                read_address_feature = node;
                if (node == NODE_LAST) state_nxt = DRAIN;
            end
            // Leave once nothing is left ahead of the write stage; the final
            // write of the column lands in the last DRAIN cycle.
            DRAIN:   if (!pending) state_nxt = (col == COL_LAST) ? DONE : FETCH_W;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Column / node counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col  <= '0;
            node <= '0;
        end else begin
            case (state)
                IDLE:    if (start) col <= '0;
                LATCH_W: node <= '0;
                STREAM:  node <= node + 1'b1;
                DRAIN:   if (!pending && col != COL_LAST) col <= col + 1'b1;
                default: ;
            endcase
        end
    end

    // Weight operand: loaded when the column read returns, held for the column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 vm_weight_line <= '0;
        else if (state == LATCH_W) vm_weight_line <= weight_line;
    end

    // Row-major product address for the row being issued.
    assign tag = FMWM_AW'(node) * FMWM_AW'(WEIGHT_COLS) + FMWM_AW'(col);

    fm_wm_pipe #(
        .WEIGHT_ROWS    (WEIGHT_ROWS),
        .WEIGHT_WIDTH   (WEIGHT_WIDTH),
        .DOT_PROD_WIDTH (DOT_PROD_WIDTH),
        .ADDR_W         (FMWM_AW)
    ) u_pipe (
        .clk             (clk),
        .rst             (reset),
        .issue           (read_enable_feature),
        .tag_in          (tag),
        .feature_line    (feature_line),
        .mul_out         (vm_mul_out),
        .vm_feature_line (vm_feature_line),
        .pending         (pending),
        .write_enable    (write_enable_fm_wm),
        .write_address   (write_address_fm_wm),
        .write_data      (write_data_fm_wm)
    );

`ifdef FEATURE_TRANSFORM_CYCLE_CNT_EN
    // Run-length counter: cleared on accepted start, saturating, held when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          busy_cycles <= '0;
        else if (state == IDLE && start)    busy_cycles <= '0;
        else if (state != IDLE && busy_cycles != 16'hFFFF)
                                            busy_cycles <= busy_cycles + 16'd1;
    end
`else
    // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_feature_transform_ctrl.sv
// Bench for feature_transform_ctrl: models weight/feature memories and
// vectormul, scoreboards every product-memory write.
module tb_feature_transform_ctrl;

    localparam int NN = 6;
    localparam int WR = 96;
    localparam int WC = 3;
    localparam int WW = 5;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset, start;
    logic                   read_enable_weight, read_enable_feature;
    logic [1:0]             read_address_weight;
    logic [2:0]             read_address_feature;
    logic [WR-1:0][WW-1:0]  weight_line, feature_line, vm_weight_line, vm_feature_line;
    logic [DW-1:0]          vm_mul_out, write_data_fm_wm;
    logic                   write_enable_fm_wm, done;
    logic [4:0]             write_address_fm_wm;
`ifdef FEATURE_TRANSFORM_CYCLE_CNT_EN
    logic [15:0]            busy_cycles;
`endif

    feature_transform_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .read_enable_weight(read_enable_weight), .read_address_weight(read_address_weight),
        .weight_line(weight_line),
        .read_enable_feature(read_enable_feature), .read_address_feature(read_address_feature),
        .feature_line(feature_line),
        .vm_weight_line(vm_weight_line), .vm_feature_line(vm_feature_line),
        .vm_mul_out(vm_mul_out),
        .write_enable_fm_wm(write_enable_fm_wm), .write_address_fm_wm(write_address_fm_wm),
        .write_data_fm_wm(write_data_fm_wm), .done(done)
`ifdef FEATURE_TRANSFORM_CYCLE_CNT_EN
       ,.busy_cycles(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mode_r = 0;
    int done_cnt = 0;
    int done_cyc = -1;

    typedef struct { logic [4:0] addr; logic [15:0] data; } wr_t;
    wr_t sb[$];

    typedef struct { int mode; int restart; int fixed_data; } vec_t;
    vec_t vecs[4];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Element values: mode 0 all ones, 1 all 31, 2 distinct per row/column.
    function automatic int wval(int mode, int c);
        return (mode == 0) ? 1 : (mode == 1) ? 31 : c + 1;
    endfunction
    function automatic int fval(int mode, int n);
        return (mode == 0) ? 1 : (mode == 1) ? 31 : n;
    endfunction
    function automatic logic [WR-1:0][WW-1:0] fill(int v);
        logic [WR-1:0][WW-1:0] l;
        for (int i = 0; i < WR; i++) l[i] = WW'(v);
        return l;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories.
    always @(posedge clk) begin
        if (read_enable_weight)  weight_line  <= fill(wval(mode_r, int'(read_address_weight)));
        if (read_enable_feature) feature_line <= fill(fval(mode_r, int'(read_address_feature)));
    end

    // vectormul model.
    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < WR; i++) s += int'(vm_weight_line[i]) * int'(vm_feature_line[i]);
        vm_mul_out = s[15:0];
    end

    // Output monitor away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (write_enable_fm_wm) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(write_address_fm_wm), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("write_addr", 32'(write_address_fm_wm), 32'(e.addr));
                    check("write_data", 32'(write_data_fm_wm), 32'(e.data));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_all(int mode, int fixed);
        sb.delete();
        for (int c = 0; c < WC; c++)
            for (int n = 0; n < NN; n++) begin
                wr_t e;
                e.addr = 5'(n * WC + c);
                e.data = (fixed >= 0) ? 16'(fixed) : 16'((WR * fval(mode, n) * wval(mode, c)) & 32'hFFFF);
                sb.push_back(e);
            end
    endtask

    task automatic check_idle_outputs(string nm);
        check({nm, "_re_w"},  32'(read_enable_weight), 0);
        check({nm, "_ra_w"},  32'(read_address_weight), 0);
        check({nm, "_re_f"},  32'(read_enable_feature), 0);
        check({nm, "_ra_f"},  32'(read_address_feature), 0);
        check({nm, "_vm_w"},  32'(|vm_weight_line), 0);
        check({nm, "_vm_f"},  32'(|vm_feature_line), 0);
        check({nm, "_we"},    32'(write_enable_fm_wm), 0);
        check({nm, "_wa"},    32'(write_address_fm_wm), 0);
        check({nm, "_wd"},    32'(write_data_fm_wm), 0);
        check({nm, "_done"},  32'(done), 0);
`ifdef FEATURE_TRANSFORM_CYCLE_CNT_EN
        check({nm, "_busy"},  32'(busy_cycles), 0);
`endif
    endtask

    task automatic run_vec(int mode, int restart, int fixed);
        int c0;
        mode_r = mode;
        push_all(mode, fixed);
        done_cnt = 0;
        done_cyc = -1;
        @(posedge clk); #1 start = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            start = (restart > 0 && cyc == c0 + restart);
        end
        start = 1'b0;
        check("done_count", 32'(done_cnt), 1);
        check("done_cycle", 32'(done_cyc - c0), 34);
        check("writes_missing", 32'(sb.size()), 0);
`ifdef FEATURE_TRANSFORM_CYCLE_CNT_EN
        check("busy_cycles", 32'(busy_cycles), 34);
`endif
    endtask

    initial begin
        int c0;
        vecs[0] = '{mode: 0, restart: -1, fixed_data: 96};
        vecs[1] = '{mode: 1, restart: -1, fixed_data: 26720};
        vecs[2] = '{mode: 2, restart: -1, fixed_data: -1};
        vecs[3] = '{mode: 2, restart: 10, fixed_data: -1};

        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;

        for (int v = 0; v < 4; v++) run_vec(vecs[v].mode, vecs[v].restart, vecs[v].fixed_data);

        // Reset at cycle 15 of a run: nothing further may be written.
        mode_r = 0;
        push_all(0, 96);
        done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        while (cyc < c0 + 15) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check_idle_outputs("midrun_reset");
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 40; k++) @(posedge clk);
        #1;
        check("done_after_reset", 32'(done_cnt), 0);
        check_idle_outputs("post_reset");

        run_vec(0, -1, 96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
